// File: rtl/pwr_seq_pkg.sv
// Shared types, default timing constants and small helpers for the power sequencer.
package pwr_seq_pkg;

  // Encoding is visible on seq_state, so values are fixed explicitly.
  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StRamp     = 3'd1,
    StSettle   = 3'd2,
    StPorWait  = 3'd3,
    StOn       = 3'd4,
    StShutdown = 3'd5,
    StFault    = 3'd6
  } seq_state_e;

  localparam int unsigned MaxRails       = 16;
  localparam int unsigned DefNRails      = 4;
  localparam int unsigned DefClkHz       = 50_000_000;
  localparam int unsigned DefSeqDlyMs    = 6;
  localparam int unsigned DefPgTimeoutMs = 50;
  localparam int unsigned DefPorDlyMs    = 100;
  localparam int unsigned DefOffDlyMs    = 2;

  // Largest of the four delays; sizes the shared ms counter.
  function automatic int unsigned max_delay(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Clear the highest set bit of v (no change when v is zero).
  function automatic logic [MaxRails-1:0] clr_highest(input logic [MaxRails-1:0] v);
    logic [MaxRails-1:0] r;
    logic                found;
    r     = v;
    found = 1'b0;
    for (int i = MaxRails - 1; i >= 0; i--) begin
      if (v[i] && !found) begin
        r[i]  = 1'b0;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Index of the lowest set bit of v (zero when v is zero).
  function automatic logic [3:0] lowest_set(input logic [MaxRails-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = MaxRails - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pwr_seq_ms_tick.sv
// Free-running prescaler producing a one-cycle tick every CLK_HZ/1000 clocks.
module pwr_seq_ms_tick
  import pwr_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefClkHz
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned Div  = CLK_HZ / 1000;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap at Div-1 so the tick period is exactly Div clocks.
  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Multi-rail power sequencer: enables rails in order, waits for power-good and settle
// time on each, releases CPU reset, and powers down in reverse order on request or fault.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned N_RAILS       = DefNRails,
  parameter int unsigned CLK_HZ        = DefClkHz,
  parameter int unsigned SEQ_DLY_MS    = DefSeqDlyMs,
  parameter int unsigned PG_TIMEOUT_MS = DefPgTimeoutMs,
  parameter int unsigned POR_DLY_MS    = DefPorDlyMs,
  parameter int unsigned OFF_DLY_MS    = DefOffDlyMs
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seq_req,
  input  logic [N_RAILS-1:0] pgood,
  input  logic               fault_clr,
  output logic [N_RAILS-1:0] rail_en,
  output logic               por_n,
  output logic               fault,
  output logic [3:0]         fault_rail,
  output logic [2:0]         seq_state
);

  localparam int unsigned MaxDly = max_delay(SEQ_DLY_MS, PG_TIMEOUT_MS, POR_DLY_MS, OFF_DLY_MS);
  localparam int unsigned MsW    = $clog2(MaxDly + 1);

  // A D ms delay completes on the tick that would bring the count to D.
  localparam logic [MsW-1:0] SeqLast  = MsW'(SEQ_DLY_MS - 1);
  localparam logic [MsW-1:0] PgToLast = MsW'(PG_TIMEOUT_MS - 1);
  localparam logic [MsW-1:0] PorLast  = MsW'(POR_DLY_MS - 1);
  localparam logic [MsW-1:0] OffLast  = MsW'(OFF_DLY_MS - 1);
  localparam logic [3:0]     LastIdx  = 4'(N_RAILS - 1);

  if ((N_RAILS < 1) || (N_RAILS > MaxRails)) begin : gen_bad_rails
    $error("pwr_seq_ctrl: N_RAILS must be in 1..16");
  end
  if ((SEQ_DLY_MS < 1) || (PG_TIMEOUT_MS < 1) || (POR_DLY_MS < 1) || (OFF_DLY_MS < 1))
  begin : gen_bad_delay
    $error("pwr_seq_ctrl: all delays must be at least 1 ms");
  end
  if (CLK_HZ < 1000) begin : gen_bad_clk
    $error("pwr_seq_ctrl: CLK_HZ must be at least 1000");
  end

  seq_state_e         state_q, state_d;
  logic [N_RAILS-1:0] pg_meta_q, pg_sync_q;
  logic [N_RAILS-1:0] rail_en_q, rail_en_d;
  logic [3:0]         idx_q, idx_d;
  logic [MsW-1:0]     ms_cnt_q, ms_cnt_d;
  logic               por_n_q, por_n_d;
  logic               fault_q, fault_d;
  logic [3:0]         fault_rail_q, fault_rail_d;

  logic               tick;
  logic [N_RAILS-1:0] pg_bad;
  logic [N_RAILS-1:0] rail_en_dn;
  logic [N_RAILS-1:0] next_bit;
  logic [3:0]         bad_idx;
  logic               pg_cur;
  logic               pg_lost;
  logic               ramp_timeout;
  logic               seq_dly_done;
  logic               pg_timeout;
  logic               por_dly_done;
  logic               off_dly_done;

  pwr_seq_ms_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous power-good inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_meta_q <= '0;
      pg_sync_q <= '0;
    end else begin
      pg_meta_q <= pgood;
      pg_sync_q <= pg_meta_q;
    end
  end

  // Rail currently ramping, enabled rails that lost power-good, and the next shutdown step.
  assign pg_cur     = |(pg_sync_q & (N_RAILS'(1) << idx_q));
  assign pg_bad     = rail_en_q & ~pg_sync_q;
  assign pg_lost    = |pg_bad;
  assign bad_idx    = lowest_set(MaxRails'(pg_bad));
  assign rail_en_dn = N_RAILS'(clr_highest(MaxRails'(rail_en_q)));
  assign next_bit   = N_RAILS'(1) << (idx_q + 4'd1);

  assign seq_dly_done = tick && (ms_cnt_q == SeqLast);
  assign pg_timeout   = tick && (ms_cnt_q == PgToLast);
  assign por_dly_done = tick && (ms_cnt_q == PorLast);
  assign off_dly_done = tick && (ms_cnt_q == OffLast);
  // Power-good arriving on the timeout tick wins over the timeout.
  assign ramp_timeout = pg_timeout && !pg_cur;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fault detection outranks a dropped request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff: begin
        if (seq_req && !fault_q) state_d = StRamp;
      end
      StRamp: begin
        if (ramp_timeout || !seq_req) begin
          state_d = StShutdown;
        end else if (pg_cur) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (pg_lost || !seq_req) begin
          state_d = StShutdown;
        end else if (seq_dly_done) begin
          state_d = (idx_q == LastIdx) ? StPorWait : StRamp;
        end
      end
      StPorWait: begin
        if (pg_lost || !seq_req) begin
          state_d = StShutdown;
        end else if (por_dly_done) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (pg_lost || !seq_req) state_d = StShutdown;
      end
      StShutdown: begin
        // Leave as soon as the last enabled rail is switched off.
        if ((rail_en_q == '0) || (off_dly_done && (rail_en_dn == '0))) begin
          state_d = fault_q ? StFault : StOff;
        end
      end
      StFault: begin
        if (fault_clr && !seq_req) state_d = StOff;
      end
      default: state_d = StOff;
    endcase
  end

  // Output/datapath next values: rail enables, index, fault latch, ms counter and por_n.
  always_comb begin
    rail_en_d    = rail_en_q;
    idx_d        = idx_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    por_n_d      = (state_d == StOn);
    ms_cnt_d     = ms_cnt_q;
    if (tick && (ms_cnt_q != '1)) ms_cnt_d = ms_cnt_q + MsW'(1);

    case (state_q)
      StOff: begin
        rail_en_d = '0;
        if (state_d == StRamp) begin
          idx_d     = '0;
          rail_en_d = N_RAILS'(1);
        end
      end
      StRamp: begin
        if (ramp_timeout) begin
          fault_d      = 1'b1;
          fault_rail_d = idx_q;
        end
      end
      StSettle: begin
        if (pg_lost) begin
          fault_d      = 1'b1;
          fault_rail_d = bad_idx;
        end else if (state_d == StRamp) begin
          idx_d     = idx_q + 4'd1;
          rail_en_d = rail_en_q | next_bit;
        end
      end
      StPorWait, StOn: begin
        if (pg_lost) begin
          fault_d      = 1'b1;
          fault_rail_d = bad_idx;
        end
      end
      StShutdown: begin
        // Each disable restarts the spacing delay.
        if (off_dly_done) begin
          rail_en_d = rail_en_dn;
          ms_cnt_d  = '0;
        end
      end
      StFault: begin
        rail_en_d = '0;
        if (state_d == StOff) begin
          fault_d      = 1'b0;
          fault_rail_d = '0;
        end
      end
      default: rail_en_d = '0;
    endcase

    // Every state entry restarts timing; entering shutdown drops the top rail at once.
    if (state_d != state_q) begin
      ms_cnt_d = '0;
      if (state_d == StShutdown) rail_en_d = rail_en_dn;
    end
  end

  // Datapath registers; asynchronous reset drops every rail immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rail_en_q    <= '0;
      idx_q        <= '0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
      por_n_q      <= 1'b0;
      ms_cnt_q     <= '0;
    end else begin
      rail_en_q    <= rail_en_d;
      idx_q        <= idx_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
      por_n_q      <= por_n_d;
      ms_cnt_q     <= ms_cnt_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign por_n      = por_n_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed-random bench for pwr_seq_ctrl; expected edge times come from millisecond arithmetic.
module tb_pwr_seq_ctrl;

  localparam int unsigned NR      = 3;
  localparam int unsigned ClkHz   = 10_000;
  localparam int          TickDiv = ClkHz / 1000;
  localparam int          SeqMs   = 6;
  localparam int          PgToMs  = 50;
  localparam int          PorMs   = 100;
  localparam int          OffMs   = 2;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          seq_req   = 1'b0;
  logic          fault_clr = 1'b0;
  logic [NR-1:0] pgood     = '0;
  logic [NR-1:0] rail_en;
  logic          por_n;
  logic          fault;
  logic [3:0]    fault_rail;
  logic [2:0]    seq_state;

  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  pwr_seq_ctrl #(
    .N_RAILS (NR),
    .CLK_HZ  (ClkHz)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seq_req    (seq_req),
    .pgood      (pgood),
    .fault_clr  (fault_clr),
    .rail_en    (rail_en),
    .por_n      (por_n),
    .fault      (fault),
    .fault_rail (fault_rail),
    .seq_state  (seq_state)
  );

  always #5 clk = ~clk;

  // Edge number since reset release; ticks land on every TickDiv-th edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after edge n, with a bounded number of steps.
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while ((cyc < n) && (guard < 20000)) begin
      step();
      guard++;
    end
    check("wait_edge", cyc, n);
  endtask

  // Edge on which a D ms delay started at edge e completes (D-th tick after entry).
  function automatic int done_edge(input int e, input int d_ms);
    return ((e / TickDiv) + d_ms) * TickDiv;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Rail k enabled at edge t_en; its pgood rises a random ~3 ms later.
  task automatic ramp_rail(input int k, input int t_en, output int t_done);
    int d;
    int s;
    d = $urandom_range(25, 35);
    wait_edge(t_en - 1);
    check($sformatf("rail%0d_pre_en", k), rail_en, mask_of(k));
    step();
    check($sformatf("rail%0d_en", k), rail_en, mask_of(k + 1));
    check($sformatf("rail%0d_ramp", k), seq_state, 1);
    wait_edge(t_en + d);
    pgood[k] = 1'b1;
    s = t_en + d + 3;  // two synchronizer flops, then the FSM edge
    wait_edge(s - 1);
    check($sformatf("rail%0d_still_ramp", k), seq_state, 1);
    step();
    check($sformatf("rail%0d_settle", k), seq_state, 2);
    t_done = done_edge(s, SeqMs);
  endtask

  task automatic power_up(output int t_on);
    int t;
    seq_req = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < NR; k++) ramp_rail(k, t, t);
    wait_edge(t);
    check("por_wait_state", seq_state, 3);
    check("por_wait_por", por_n, 0);
    t_on = done_edge(t, PorMs);
    wait_edge(t_on - 1);
    check("por_still_low", por_n, 0);
    step();
    check("por_release", por_n, 1);
    check("on_state", seq_state, 4);
    check("on_rails", rail_en, mask_of(NR));
  endtask

  // Shutdown entered at edge t_sd with n_on rails (always rails 0..n_on-1) enabled.
  task automatic check_shutdown(input int t_sd, input int n_on, input logic [2:0] end_state,
                                input string tag);
    int t;
    int n;
    t = t_sd;
    n = n_on - 1;
    wait_edge(t);
    check({tag, "_sd_state"}, seq_state, 5);
    check({tag, "_sd_por"}, por_n, 0);
    check({tag, "_sd_rails"}, rail_en, mask_of(n));
    while (n > 0) begin
      t = done_edge(t, OffMs);
      wait_edge(t - 1);
      check({tag, "_hold"}, rail_en, mask_of(n));
      step();
      n--;
      check({tag, "_off"}, rail_en, mask_of(n));
    end
    wait_edge(t + 2);
    check({tag, "_end_state"}, seq_state, end_state);
  endtask

  initial begin
    int t;
    int t_on;
    int j;
    int to;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", seq_state, 0);
    check("rst_rails", rail_en, 0);
    check("rst_por", por_n, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_rail", fault_rail, 0);
    rst = 1'b0;
    repeat (5) step();
    check("idle_off", seq_state, 0);

    // Normal power-up, then a stray fault_clr while ON.
    power_up(t_on);
    wait_edge(t_on + 5);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    wait_edge(t_on + 20);
    check("clr_in_on_state", seq_state, 4);
    check("clr_in_on_fault", fault, 0);

    // Requested power-down from ON.
    t = cyc;
    seq_req = 1'b0;
    check_shutdown(t + 1, NR, 0, "down");
    check("down_fault", fault, 0);
    pgood = '0;
    repeat (5) step();

    // Power-good loss on a random rail while ON.
    power_up(t_on);
    j = $urandom_range(0, NR - 1);
    wait_edge(t_on + 30);
    t = cyc;
    pgood[j] = 1'b0;
    wait_edge(t + 2);
    check("loss_pre_state", seq_state, 4);
    step();
    check("loss_fault", fault, 1);
    check("loss_fault_rail", fault_rail, j);
    check_shutdown(t + 3, NR, 6, "loss");
    pgood = '0;
    check("loss_fault_held", fault, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    step();
    check("clr_req_hi_state", seq_state, 6);
    check("clr_req_hi_fault", fault, 1);
    check("clr_req_hi_rail", fault_rail, j);
    seq_req   = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_state", seq_state, 0);
    check("clr_fault", fault, 0);
    check("clr_fault_rail", fault_rail, 0);
    repeat (5) step();

    // Rail 1 never reports power-good.
    seq_req = 1'b1;
    t = cyc + 1;
    ramp_rail(0, t, t);
    wait_edge(t);
    check("to_rail1_en", rail_en, 3);
    to = done_edge(t, PgToMs);
    wait_edge(to - 1);
    check("to_pre_state", seq_state, 1);
    check("to_pre_fault", fault, 0);
    step();
    check("to_fault", fault, 1);
    check("to_fault_rail", fault_rail, 1);
    check_shutdown(to, 2, 6, "to");
    pgood     = '0;
    seq_req   = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("to_clr_state", seq_state, 0);
    repeat (5) step();

    // Power-good lands on the very timeout tick.
    seq_req = 1'b1;
    t  = cyc + 1;
    to = done_edge(t, PgToMs);
    wait_edge(to - 3);
    pgood[0] = 1'b1;
    wait_edge(to - 1);
    check("edge_pre_state", seq_state, 1);
    step();
    check("edge_settle", seq_state, 2);
    check("edge_no_fault", fault, 0);
    seq_req = 1'b0;
    step();
    check("edge_abort_state", seq_state, 5);
    check("edge_abort_rails", rail_en, 0);
    repeat (2) step();
    check("edge_abort_off", seq_state, 0);
    check("edge_abort_fault", fault, 0);
    pgood = '0;
    repeat (5) step();

    // Asynchronous reset while settling rail 1.
    seq_req = 1'b1;
    t = cyc + 1;
    ramp_rail(0, t, t);
    ramp_rail(1, t, t);
    step();
    step();
    check("rst_mid_pre", seq_state, 2);
    rst = 1'b1;
    #1;
    check("rst_mid_rails", rail_en, 0);
    check("rst_mid_por", por_n, 0);
    check("rst_mid_state", seq_state, 0);
    pgood = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_edge(1);
    check("restart_rails", rail_en, 1);
    check("restart_state", seq_state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
PWR_SEQ_CTRL -- requirements
Module: pwr_seq_ctrl

Interface
REQ-001 SHALL have parameter N_RAILS, default 4: number of sequenced rails, legal range 1..16.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000: clk frequency, used to derive the 1 ms tick.
REQ-003 SHALL have parameter SEQ_DLY_MS, default 6: settle time after a rail's pgood before the next rail is enabled.
REQ-004 SHALL have parameter PG_TIMEOUT_MS, default 50: maximum wait for pgood after a rail enable.
REQ-005 SHALL have parameter POR_DLY_MS, default 100: delay from last-rail settle to por_n release.
REQ-006 SHALL have parameter OFF_DLY_MS, default 2: spacing between successive rail disables.
REQ-007 SHALL have port clk  in  1  system clock; one clock domain; all logic on its rising edge.
REQ-008 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-009 SHALL have port seq_req  in  1  level request: 1 = power up and stay on, 0 = power down.
REQ-010 SHALL have port pgood  in  N_RAILS  per-rail power-good, asynchronous, active high.
REQ-011 SHALL have port fault_clr  in  1  single-cycle pulse that clears a latched fault.
REQ-012 SHALL have port rail_en  out  N_RAILS  per-rail enable, active high.
REQ-013 SHALL have port por_n  out  1  CPU power-on reset, active low.
REQ-014 SHALL have port fault  out  1  latched sequencing fault.
REQ-015 SHALL have port fault_rail  out  4  index of the first failing rail.
REQ-016 SHALL have port seq_state  out  3  current state encoding, for debug and LEDs.

Function
REQ-017 SHALL pass pgood through a 2-flop synchronizer; all pgood references below mean the synchronized value.
REQ-018 SHALL generate a 1-cycle tick every CLK_HZ/1000 clocks; one ms counter is shared by all states and cleared on every state entry.
REQ-019 SHALL define a delay of D ms as complete on the D-th tick after state entry, so elapsed time lies in (D-1, D] ms.
REQ-020 SHALL implement states OFF=0, RAMP=1, SETTLE=2, POR_WAIT=3, ON=4, SHUTDOWN=5, FAULT=6 and drive seq_state with that encoding.
REQ-021 In OFF: rail_en=0 and por_n=0; seq_req=1 with fault=0 sets idx=0, sets rail_en[0], and enters RAMP.
REQ-022 In RAMP: pgood[idx]=1 enters SETTLE; on the PG_TIMEOUT_MS tick, SHALL set fault, set fault_rail=idx, and enter SHUTDOWN; if both occur in the same cycle, pgood wins.
REQ-023 In SETTLE, on completion of SEQ_DLY_MS:
- if idx=N_RAILS-1, enter POR_WAIT;
- otherwise increment idx, set rail_en[idx], and enter RAMP.
REQ-024 In SETTLE or POR_WAIT: any enabled rail with pgood=0 SHALL latch fault with fault_rail = lowest such index and enter SHUTDOWN.
REQ-025 In POR_WAIT: on completion of POR_DLY_MS, set por_n=1 and enter ON.
REQ-026 In ON: pgood loss on any rail causes a fault per REQ-024; seq_req=0 enters SHUTDOWN without fault.
REQ-027 seq_req=0 seen in RAMP, SETTLE or POR_WAIT SHALL enter SHUTDOWN; fault detection has priority over seq_req in the same cycle.
REQ-028 On the cycle SHUTDOWN is entered, por_n SHALL go 0.
REQ-029 In SHUTDOWN, rails SHALL be disabled highest-enabled-first, one per OFF_DLY_MS, with the first disable on entry.
REQ-030 When SHUTDOWN leaves all rails off, the block SHALL enter FAULT if fault=1, otherwise OFF.
REQ-031 In FAULT: all outputs are held off; fault_clr=1 with seq_req=0 clears fault and fault_rail and enters OFF; fault_clr with seq_req=1 is ignored.
REQ-032 fault_clr in any state other than FAULT SHALL be ignored.
REQ-033 The ms counter width SHALL be clog2(max(all delays)+1) and SHALL saturate, never wrap.

Reset
REQ-034 While rst=1, the block SHALL force: state=OFF, rail_en=0, por_n=0, fault=0, fault_rail=0, idx=0, ms counter=0, tick prescaler=0, synchronizers=0.
REQ-035 Reset asserted mid-sequence SHALL drop all rail_en asynchronously, with no reverse-order shutdown.

Structure
REQ-036 The state encoding and default delay constants SHALL live in shared package pwr_seq_pkg.
REQ-037 The 1 ms tick SHALL be a sub-module, pwr_seq_ms_tick (parameter CLK_HZ; ports clk, rst, tick).
REQ-038 Parameter legality (N_RAILS range, all delays >=1) SHALL be checked at elaboration.

Verification (CLK_HZ=10_000, i.e. tick every 10 clk; N_RAILS=3; other parameters at default)
REQ-039 seq_req=1, each pgood rising 3 ms after its enable:
- rail_en = 001 -> 011 -> 111, spaced approx. 9 ms;
- por_n=1 100 ms after the rail-2 settle completes; seq_state=4.
REQ-040 From ON, seq_req=0: por_n=0 the next cycle; rail_en = 011, then 001 2 ms later, then 000 2 ms later; seq_state=0.
REQ-041 pgood[1] never rises: fault=1 and fault_rail=1 at 50 ms after rail_en[1] rises; rails shut down in reverse order; seq_state=6.
REQ-042 In ON, pgood[0] drops for 1 ms: fault_rail=0, full shutdown, FAULT state. Then fault_clr with seq_req=1 has no effect; fault_clr with seq_req=0 returns the block to OFF.
REQ-043 rst pulsed while in SETTLE of rail 1: rail_en=000 and por_n=0 within the same cycle. After release, seq_req=1 restarts at rail 0.
REQ-044 pgood[0] rises on the exact cycle of the 50th tick: no fault; SETTLE is entered.
